// File: rtl/rtc_edit_ctrl.sv
// rtc_edit_ctrl: turns debounced button levels into edit events, auto-repeats
// up/down, runs the hour/date/chronometer programming FSM and strobes commit
// when an edit session is closed.
//
// state | meaning
// IDLE  | not editing; val outputs show the hour set
// HORA  | editing hh:mm:ss
// FECHA | editing dd/month/yy
// CRONO | editing chronometer hh:mm:ss
module rtc_edit_ctrl #(
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       au,
  input  logic       dis,
  input  logic       l,
  input  logic       r,
  input  logic       prh,
  input  logic       prf,
  input  logic       prc,
  output logic [1:0] mode,
  output logic [1:0] cursor,
  output logic [6:0] val0,
  output logic [6:0] val1,
  output logic [6:0] val2,
  output logic       commit,
  output logic [1:0] commit_mode
);

  typedef enum logic [1:0] {IDLE = 2'd0, HORA = 2'd1, FECHA = 2'd2, CRONO = 2'd3} mode_t;

  // Repeat timers are down-counters: preloaded while idle, event at zero.
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LD  = CW'(REP_CYC - 1);

  // bit order: 0 au, 1 dis, 2 l, 3 r, 4 prh, 5 prf, 6 prc
  logic [6:0]          lvl_q, lvl_d, pe;
  mode_t               mode_q, mode_n;
  logic [1:0]          cursor_q;
  logic [CW-1:0]       au_cnt_q, dis_cnt_q;
  logic                both, au_tick, dis_tick, inc_ev, dec_ev, mv_r, mv_l;
  logic                commit_c, edit_we;
  logic [2:0][6:0]     hora_q, fecha_q, crono_q, act;
  logic [6:0]          sel_val, fmin, fmax, new_val;

  // Register the levels and keep a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= '0;
      lvl_d <= '0;
    end else begin
      lvl_q <= {prc, prf, prh, r, l, dis, au};
      lvl_d <= lvl_q;
    end
  end

  assign pe   = lvl_q & ~lvl_d;
  assign both = lvl_q[0] & lvl_q[1];

  assign au_tick  = lvl_q[0] & ~both & (au_cnt_q == '0);
  assign dis_tick = lvl_q[1] & ~both & (dis_cnt_q == '0);

  // Increment hold/repeat timer; held at the hold preload whenever released or contested.
  always_ff @(posedge clk) begin
    if (reset || !lvl_q[0] || both) au_cnt_q <= HOLD_LD;
    else if (au_cnt_q == '0)        au_cnt_q <= REP_LD;
    else                            au_cnt_q <= au_cnt_q - CW'(1);
  end

  // Decrement hold/repeat timer, same scheme as the increment one.
  always_ff @(posedge clk) begin
    if (reset || !lvl_q[1] || both) dis_cnt_q <= HOLD_LD;
    else if (dis_cnt_q == '0)       dis_cnt_q <= REP_LD;
    else                            dis_cnt_q <= dis_cnt_q - CW'(1);
  end

  assign inc_ev = (pe[0] | au_tick) & ~both;
  assign dec_ev = (pe[1] | dis_tick) & ~both;
  assign mv_r   = pe[3] & ~pe[2];
  assign mv_l   = pe[2] & ~pe[3];

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= IDLE;
    else       mode_q <= mode_n;
  end

  // Next mode and exit strobe; entry priority prh > prf > prc.
  always_comb begin
    mode_n   = mode_q;
    commit_c = 1'b0;
    unique case (mode_q)
      IDLE: begin
        if (pe[4])      mode_n = HORA;
        else if (pe[5]) mode_n = FECHA;
        else if (pe[6]) mode_n = CRONO;
      end
      HORA:  if (pe[4]) begin mode_n = IDLE; commit_c = 1'b1; end
      FECHA: if (pe[5]) begin mode_n = IDLE; commit_c = 1'b1; end
      CRONO: if (pe[6]) begin mode_n = IDLE; commit_c = 1'b1; end
      default: mode_n = IDLE;
    endcase
  end

  // Cursor: cleared on every mode change, moves modulo 3 only while editing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_q <= 2'd0;
    end else if (mode_n != mode_q) begin
      cursor_q <= 2'd0;
    end else if (mode_q != IDLE) begin
      if (mv_r)      cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
      else if (mv_l) cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
    end
  end

  // Active field set, selected field, its limits and the wrapped new value.
  always_comb begin
    act = hora_q;
    if (mode_q == FECHA)      act = fecha_q;
    else if (mode_q == CRONO) act = crono_q;
    sel_val = act[0];
    for (int i = 1; i < 3; i++)
      if (cursor_q == 2'(i)) sel_val = act[i];
    fmin = 7'd0;
    fmax = 7'd59;
    if (mode_q == FECHA) begin
      case (cursor_q)
        2'd0:    begin fmin = 7'd1; fmax = 7'd31; end
        2'd1:    begin fmin = 7'd1; fmax = 7'd12; end
        default: begin fmin = 7'd0; fmax = 7'd99; end
      endcase
    end else if (cursor_q == 2'd0) begin
      fmax = 7'd23;
    end
    if (inc_ev) new_val = (sel_val == fmax) ? fmin : sel_val + 7'd1;
    else        new_val = (sel_val == fmin) ? fmax : sel_val - 7'd1;
  end

  assign edit_we = (mode_q != IDLE) & (inc_ev | dec_ev);

  // Field storage; the edit uses the cursor value from before any move this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hora_q  <= '0;
      fecha_q <= {7'd0, 7'd1, 7'd1};
      crono_q <= '0;
    end else if (edit_we) begin
      for (int i = 0; i < 3; i++) begin
        if (cursor_q == 2'(i)) begin
          case (mode_q)
            HORA:    hora_q[i]  <= new_val;
            FECHA:   fecha_q[i] <= new_val;
            CRONO:   crono_q[i] <= new_val;
            default: ;
          endcase
        end
      end
    end
  end

  assign mode        = mode_q;
  assign cursor      = cursor_q;
  assign val0        = act[0];
  assign val1        = act[1];
  assign val2        = act[2];
  assign commit      = commit_c & ~reset;
  assign commit_mode = commit ? mode_q : 2'd0;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Bench for rtc_edit_ctrl: directed button sequences; expected snapshots and
// commit modes are queued by the stimulus and consumed by a negedge monitor.
module tb_rtc_edit_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int CW   = 4;

  localparam logic [6:0] B_AU  = 7'h01;
  localparam logic [6:0] B_DIS = 7'h02;
  localparam logic [6:0] B_L   = 7'h04;
  localparam logic [6:0] B_R   = 7'h08;
  localparam logic [6:0] B_PRH = 7'h10;
  localparam logic [6:0] B_PRF = 7'h20;
  localparam logic [6:0] B_PRC = 7'h40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] btn = '0;
  logic [1:0] mode, cursor, commit_mode;
  logic [6:0] val0, val1, val2;
  logic       commit;

  typedef struct {
    int         id;
    logic [1:0] m;
    logic [1:0] c;
    logic [6:0] v0;
    logic [6:0] v1;
    logic [6:0] v2;
  } snap_t;

  snap_t      snap_q[$];
  logic [1:0] cm_q[$];
  int         errors = 0;
  int         checks = 0;
  int         snap_id = 0;
  snap_t      s;
  logic [1:0] lm;

  always #5 clk = ~clk;

  rtc_edit_ctrl #(.HOLD_CYC(HOLD), .REP_CYC(REP), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .au(btn[0]), .dis(btn[1]), .l(btn[2]), .r(btn[3]),
    .prh(btn[4]), .prf(btn[5]), .prc(btn[6]),
    .mode(mode), .cursor(cursor),
    .val0(val0), .val1(val1), .val2(val2),
    .commit(commit), .commit_mode(commit_mode)
  );

  task automatic chk(input string name, input int id, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s (snap %0d): got %0d want %0d", name, id, got, want);
    end
  endtask

  // Monitor: pops an expected commit mode on every strobe and an expected snapshot when queued.
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      if (cm_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got commit_mode=%0d want no commit", commit_mode);
      end else begin
        lm = cm_q.pop_front();
        chk("commit_mode", -1, int'(commit_mode), int'(lm));
      end
    end
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk("mode",   s.id, int'(mode),   int'(s.m));
      chk("cursor", s.id, int'(cursor), int'(s.c));
      chk("val0",   s.id, int'(val0),   int'(s.v0));
      chk("val1",   s.id, int'(val1),   int'(s.v1));
      chk("val2",   s.id, int'(val2),   int'(s.v2));
    end
  end

  task automatic expect_state(input logic [1:0] m, input logic [1:0] c,
                              input logic [6:0] v0, input logic [6:0] v1, input logic [6:0] v2);
    snap_t e;
    e.id = snap_id;
    e.m = m; e.c = c; e.v0 = v0; e.v1 = v1; e.v2 = v2;
    snap_id++;
    snap_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic [1:0] m);
    cm_q.push_back(m);
  endtask

  task automatic hold(input logic [6:0] m, input int n);
    @(posedge clk);
    #1 btn = btn | m;
    repeat (n) @(posedge clk);
    #1 btn = btn & ~m;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse(input logic [6:0] m);
    hold(m, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    expect_state(2'd0, 2'd0, 7'd0, 7'd0, 7'd0);

    // hour mode: move to seconds, three single increments, exit with commit
    pulse(B_PRH);
    pulse(B_R);
    pulse(B_R);
    repeat (3) pulse(B_AU);
    expect_state(2'd1, 2'd2, 7'd0, 7'd0, 7'd3);
    expect_commit(2'd1);
    pulse(B_PRH);
    expect_state(2'd0, 2'd0, 7'd0, 7'd0, 7'd3);

    // date mode: month, day and year wrap in both directions
    pulse(B_PRF);
    expect_state(2'd2, 2'd0, 7'd1, 7'd1, 7'd0);
    pulse(B_R);
    pulse(B_DIS);
    expect_state(2'd2, 2'd1, 7'd1, 7'd12, 7'd0);
    pulse(B_AU);
    expect_state(2'd2, 2'd1, 7'd1, 7'd1, 7'd0);
    pulse(B_DIS);
    expect_state(2'd2, 2'd1, 7'd1, 7'd12, 7'd0);
    pulse(B_L);
    pulse(B_DIS);
    expect_state(2'd2, 2'd0, 7'd31, 7'd12, 7'd0);
    pulse(B_L);
    pulse(B_DIS);
    expect_state(2'd2, 2'd2, 7'd31, 7'd12, 7'd99);
    expect_commit(2'd2);
    pulse(B_PRF);
    expect_state(2'd0, 2'd0, 7'd0, 7'd0, 7'd3);

    // hour mode: hold increment for HOLD + 2*REP cycles -> press, hold, two repeats
    pulse(B_PRH);
    expect_state(2'd1, 2'd0, 7'd0, 7'd0, 7'd3);
    hold(B_AU, HOLD + 2 * REP);
    expect_state(2'd1, 2'd0, 7'd4, 7'd0, 7'd3);

    // contested buttons, cursor wrap, edit-then-move ordering
    pulse(B_AU | B_DIS);
    pulse(B_L | B_R);
    expect_state(2'd1, 2'd0, 7'd4, 7'd0, 7'd3);
    pulse(B_L);
    expect_state(2'd1, 2'd2, 7'd4, 7'd0, 7'd3);
    pulse(B_AU | B_R);
    expect_state(2'd1, 2'd0, 7'd4, 7'd0, 7'd4);
    expect_commit(2'd1);
    pulse(B_PRH);
    expect_state(2'd0, 2'd0, 7'd4, 7'd0, 7'd4);

    // chronometer: foreign program buttons ignored, hh wraps 0<->23
    pulse(B_PRC);
    expect_state(2'd3, 2'd0, 7'd0, 7'd0, 7'd0);
    pulse(B_PRH);
    pulse(B_PRF);
    expect_state(2'd3, 2'd0, 7'd0, 7'd0, 7'd0);
    pulse(B_DIS);
    expect_state(2'd3, 2'd0, 7'd23, 7'd0, 7'd0);
    pulse(B_AU);
    expect_state(2'd3, 2'd0, 7'd0, 7'd0, 7'd0);
    expect_commit(2'd3);
    pulse(B_PRC);
    expect_state(2'd0, 2'd0, 7'd4, 7'd0, 7'd4);

    // simultaneous program buttons in IDLE: hour wins
    pulse(B_PRH | B_PRF);
    expect_state(2'd1, 2'd0, 7'd4, 7'd0, 7'd4);

    // reset mid-edit: back to IDLE, fields restored, no commit
    pulse(B_AU);
    expect_state(2'd1, 2'd0, 7'd5, 7'd0, 7'd4);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    expect_state(2'd0, 2'd0, 7'd0, 7'd0, 7'd0);
    pulse(B_PRF);
    expect_state(2'd2, 2'd0, 7'd1, 7'd1, 7'd0);
    expect_commit(2'd2);
    pulse(B_PRF);
    expect_state(2'd0, 2'd0, 7'd0, 7'd0, 7'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (cm_q.size() != 0) begin
      errors++;
      $display("FAIL missed_commit: got %0d pending want 0 pending", cm_q.size());
    end
    checks++;
    if (snap_q.size() != 0) begin
      errors++;
      $display("FAIL pending_snap: got %0d pending want 0 pending", snap_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
